shooter_control: RTL and testbench

Shooter-mode round controller, the counterpart of the keeper-mode glove controller: here the player takes the shot and the CPU keeper defends. Sits in the VGA overlay chain after the goal/background draw stage. Per round it picks a pseudo-random keeper dive zone and captures the player's aimed click inside the goal mouth. After a countdown it resolves goal/save, overlays the keeper and shot marker, and reports `is_scored` / `round_done` to the game FSM.

---
 rtl/shooter_control_if.sv | 13 +
 rtl/shooter_control.sv | 183 ++++++++++++++++++
 tb/tb_shooter_control.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/shooter_control_if.sv
// VGA stream bundle shared by the overlay chain: timing plus 12-bit rgb.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/shooter_control.sv
// Shooter-mode round controller: the CPU keeper dives to a pseudo-random zone, the player
// clicks a shot inside the goal mouth, and keeper/marker are overlaid on the VGA stream.
module shooter_control #(
  parameter int         TICKS_PER_SEC = 65_019_506,
  parameter int         AIM_SECONDS   = 3,
  parameter int         GOAL_X0       = 212,
  parameter int         GOAL_Y0       = 234,
  parameter int         GOAL_W        = 600,
  parameter int         GOAL_H        = 300,
  parameter int         MARK_W        = 8,
  parameter logic [1:0] SHOOTER       = 2'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic [1:0]  game_state,
  output logic        is_scored,
  output logic        round_done,
  vga_if.in           in,
  vga_if.out          out
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW = $clog2(AIM_SECONDS + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] AIM_LAST  = SW'(AIM_SECONDS - 1);
  localparam logic [11:0] X0     = 12'(GOAL_X0);
  localparam logic [11:0] Y0     = 12'(GOAL_Y0);
  localparam logic [11:0] X1     = 12'(GOAL_X0 + GOAL_W);
  localparam logic [11:0] Y1     = 12'(GOAL_Y0 + GOAL_H);
  localparam logic [11:0] ZONE_W = 12'(GOAL_W / 3);
  localparam logic [11:0] MW     = 12'(MARK_W);

  typedef enum logic [2:0] {
    IDLE, ENGAGE, AIM, SHOT, RESULT, GOAL, SAVED, TERMINATE
  } state_t;

  state_t state, next_state;

  logic [15:0]   lfsr;
  logic          mouse_q, mouse_qq, click;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sec;
  logic [1:0]    zone;
  logic [11:0]   shot_x, shot_y;
  logic          shot_valid;
  logic [11:0]   col_x0;
  logic          tick_last, aim_last, aim_hit, goal_hit, shooter;

  logic [11:0] px, py, mark_rgb, pix_rgb;
  logic        draw, in_keeper, in_mark;
  logic [10:0] s1_hcount, s1_vcount;
  logic        s1_hsync, s1_vsync, s1_hblnk, s1_vblnk;
  logic [11:0] s1_rgb;

  assign shooter   = (game_state == SHOOTER);
  assign click     = mouse_q & ~mouse_qq;
  assign col_x0    = X0 + 12'(zone) * ZONE_W;
  assign tick_last = (cnt == TICK_LAST);
  assign aim_last  = tick_last && (sec == AIM_LAST);
  assign aim_hit   = click && xpos >= X0 && xpos < X1 && ypos >= Y0 && ypos < Y1;
  assign goal_hit  = shot_valid && !(shot_x >= col_x0 && shot_x < col_x0 + ZONE_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // A valid click on the last timeout cycle wins over the timeout; leaving shooter mode aborts silently.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (shooter) next_state = ENGAGE;
      ENGAGE:      next_state = AIM;
      AIM:         if (aim_hit || aim_last) next_state = SHOT;
      SHOT:        if (tick_last) next_state = RESULT;
      RESULT:      next_state = goal_hit ? GOAL : SAVED;
      GOAL, SAVED: if (tick_last) next_state = TERMINATE;
      TERMINATE:   next_state = IDLE;
      default:     next_state = IDLE;
    endcase
    if (state != IDLE && !shooter) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr       <= 16'hACE1;
      mouse_q    <= 1'b0;
      mouse_qq   <= 1'b0;
      cnt        <= '0;
      sec        <= '0;
      zone       <= 2'd0;
      shot_x     <= 12'd0;
      shot_y     <= 12'd0;
      shot_valid <= 1'b0;
      is_scored  <= 1'b0;
      round_done <= 1'b0;
    end else begin
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      mouse_q    <= mouse_left;
      mouse_qq   <= mouse_q;
      is_scored  <= (next_state == GOAL);
      round_done <= (next_state == TERMINATE);
      case (state)
        ENGAGE: begin
          zone <= (lfsr[1:0] == 2'd3) ? 2'd1 : lfsr[1:0];
          cnt  <= '0;
          sec  <= '0;
        end
        AIM: begin
          if (aim_hit) begin
            shot_x     <= xpos;
            shot_y     <= ypos;
            shot_valid <= 1'b1;
            cnt        <= '0;
          end else if (tick_last) begin
            cnt <= '0;
            if (aim_last) shot_valid <= 1'b0;
            else          sec <= sec + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOT, GOAL, SAVED: cnt <= tick_last ? '0 : cnt + 1'b1;
        default:           cnt <= '0;
      endcase
    end
  end

  assign px        = {1'b0, in.hcount};
  assign py        = {1'b0, in.vcount};
  assign draw      = (state == SHOT) || (state == GOAL) || (state == SAVED);
  assign in_keeper = draw && px >= col_x0 && px < col_x0 + ZONE_W && py >= Y0 && py < Y1;
  assign in_mark   = draw && shot_valid && px >= shot_x && px < shot_x + MW &&
                     py >= shot_y && py < shot_y + MW;

  // Marker colour tracks the phase; the marker sits on top of the keeper box.
  always_comb begin
    mark_rgb = 12'hF00;
    if (state == SHOT)      mark_rgb = 12'hFFF;
    else if (state == GOAL) mark_rgb = 12'h0F0;
    pix_rgb = in.rgb;
    if (in_mark)        pix_rgb = mark_rgb;
    else if (in_keeper) pix_rgb = 12'h00F;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_hcount  <= '0;
      s1_vcount  <= '0;
      s1_hsync   <= 1'b0;
      s1_vsync   <= 1'b0;
      s1_hblnk   <= 1'b0;
      s1_vblnk   <= 1'b0;
      s1_rgb     <= '0;
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      s1_hcount  <= in.hcount;
      s1_vcount  <= in.vcount;
      s1_hsync   <= in.hsync;
      s1_vsync   <= in.vsync;
      s1_hblnk   <= in.hblnk;
      s1_vblnk   <= in.vblnk;
      s1_rgb     <= pix_rgb;
      out.hcount <= s1_hcount;
      out.vcount <= s1_vcount;
      out.hsync  <= s1_hsync;
      out.vsync  <= s1_vsync;
      out.hblnk  <= s1_hblnk;
      out.vblnk  <= s1_vblnk;
      out.rgb    <= s1_rgb;
    end
  end

endmodule

// File: tb/tb_shooter_control.sv
// Directed bench for shooter_control: scripted rounds with hand-computed phase timing and overlay pixels.
module tb_shooter_control;

  localparam int TPS  = 100;
  localparam int AIMS = 2;
  localparam logic [1:0] SHOOTER = 2'd2;
  localparam logic [1:0] MENU    = 2'd0;
  localparam int ST_IDLE = 0, ST_ENGAGE = 1, ST_AIM = 2, ST_SHOT = 3;
  localparam int ST_RESULT = 4, ST_GOAL = 5, ST_SAVED = 6, ST_TERM = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic        mouse_left;
  logic [1:0]  game_state;
  logic        is_scored, round_done;

  vga_if vin();
  vga_if vout();

  shooter_control #(
    .TICKS_PER_SEC(TPS),
    .AIM_SECONDS(AIMS),
    .SHOOTER(SHOOTER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .xpos(xpos),
    .ypos(ypos),
    .mouse_left(mouse_left),
    .game_state(game_state),
    .is_scored(is_scored),
    .round_done(round_done),
    .in(vin),
    .out(vout)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference keeper-zone generator, stepped in lockstep with the design's free-running LFSR.
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge rst) begin
    if (!rst) lfsr_m <= 16'hACE1;
    else      lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int zone_of(input logic [15:0] v);
    return (v[1:0] == 2'd3) ? 1 : int'(v[1:0]);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input logic [11:0] rgb);
    vin.hcount = 11'(x);
    vin.vcount = 11'(y);
    vin.rgb    = rgb;
    vin.hsync  = 1'b1;
    vin.vsync  = 1'b0;
    vin.hblnk  = 1'b0;
    vin.vblnk  = 1'b1;
  endtask

  function automatic int exp_state(input int j, input int t_shot, input bit goal, input int abort_j);
    if (abort_j >= 0 && j > abort_j) return ST_IDLE;
    if (j == 0) return ST_IDLE;
    if (j == 1) return ST_ENGAGE;
    if (j < t_shot) return ST_AIM;
    if (j < t_shot + TPS) return ST_SHOT;
    if (j == t_shot + TPS) return ST_RESULT;
    if (j <= t_shot + 2*TPS) return goal ? ST_GOAL : ST_SAVED;
    if (j == t_shot + 2*TPS + 1) return ST_TERM;
    return ST_IDLE;
  endfunction

  function automatic logic [11:0] exp_pixel(input int st, input int zone, input int sx, input int sy,
                                            input bit valid, input int x, input int y,
                                            input logic [11:0] rgb);
    int c0;
    bit draw;
    c0   = 212 + zone * 200;
    draw = (st == ST_SHOT) || (st == ST_GOAL) || (st == ST_SAVED);
    if (draw && valid && x >= sx && x < sx + 8 && y >= sy && y < sy + 8)
      return (st == ST_SHOT) ? 12'hFFF : (st == ST_GOAL) ? 12'h0F0 : 12'hF00;
    if (draw && x >= c0 && x < c0 + 200 && y >= 234 && y < 534) return 12'h00F;
    return rgb;
  endfunction

  // In IDLE every out field must equal the input from two cycles earlier.
  task automatic passthrough(input string name);
    logic [37:0] want [0:7];
    for (int i = 0; i < 10; i++) begin
      if (i >= 2)
        checkOutput($sformatf("%s vec%0d", name, i - 2),
                    64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                         vout.hblnk, vout.vblnk, vout.rgb}), 64'(want[i-2]));
      if (i < 8) begin
        vin.hcount = 11'(100 + 97 * i);
        vin.vcount = 11'(50 + 31 * i);
        {vin.hsync, vin.vsync, vin.hblnk, vin.vblnk} = 4'(i * 5 + 3);
        vin.rgb = 12'(i * 499 + 165);
        want[i] = {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.rgb};
      end
      @(negedge clk);
    end
  endtask

  // j = 0 is the negedge game_state goes to SHOOTER; probes cycle around the marker and keeper edges.
  task automatic run_round(input string name, input int zone, input bit held,
                           input int press_j, input int release_j, input int cx, input int cy,
                           input int bx, input int by, input bit valid,
                           input int t_shot, input bit goal, input int abort_j,
                           input int want_score, input int want_done);
    int n, st, x, y, c0, t_term, score_cnt, done_cnt;
    logic [11:0] eh0, eh1, rgb;
    c0 = 212 + zone * 200;
    t_term = t_shot + 2*TPS + 1;
    score_cnt = 0;
    done_cnt = 0;
    eh0 = '0;
    eh1 = '0;
    mouse_left = held;
    n = 0;
    while (zone_of(lfsr_step(lfsr_m)) != zone && n < 64) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " zone seed found"}, 64'(n < 64), 64'd1);
    for (int j = 0; j <= t_term + 3; j++) begin
      st = exp_state(j, t_shot, goal, abort_j);
      if (j >= 2) checkOutput($sformatf("%s rgb j=%0d", name, j), 64'(vout.rgb), 64'(eh1));
      checkOutput($sformatf("%s is_scored j=%0d", name, j), 64'(is_scored), 64'(st == ST_GOAL));
      checkOutput($sformatf("%s round_done j=%0d", name, j), 64'(round_done), 64'(st == ST_TERM));
      score_cnt += int'(is_scored);
      done_cnt  += int'(round_done);
      if (j == 0) game_state = SHOOTER;
      if (j == abort_j || j == t_term) game_state = MENU;
      if (j == release_j) mouse_left = 1'b0;
      if (j == press_j) begin
        xpos = 12'(cx);
        ypos = 12'(cy);
        mouse_left = 1'b1;
      end
      case (j % 11)
        0:  begin x = bx;       y = by;     end
        1:  begin x = bx + 7;   y = by + 7; end
        2:  begin x = bx + 8;   y = by + 3; end
        3:  begin x = bx + 3;   y = by - 1; end
        4:  begin x = c0;       y = 234;    end
        5:  begin x = c0 + 199; y = 533;    end
        6:  begin x = c0 + 200; y = 300;    end
        7:  begin x = c0 - 1;   y = 300;    end
        8:  begin x = c0 + 50;  y = 233;    end
        9:  begin x = c0 + 50;  y = 534;    end
        default: begin x = bx + 4; y = by + 8; end
      endcase
      rgb = 12'h5A5 ^ 12'(j);
      applyStimulus(x, y, rgb);
      eh1 = eh0;
      eh0 = exp_pixel(st, zone, bx, by, valid, x, y, rgb);
      @(negedge clk);
    end
    checkOutput({name, " is_scored cycles"}, 64'(score_cnt), 64'(want_score));
    checkOutput({name, " round_done pulses"}, 64'(done_cnt), 64'(want_done));
  endtask

  initial begin
    rst = 1'b0;
    game_state = MENU;
    mouse_left = 1'b0;
    xpos = 12'd0;
    ypos = 12'd0;
    applyStimulus(5, 5, 12'h123);
    repeat (3) @(negedge clk);
    checkOutput("reset rgb", 64'(vout.rgb), 64'd0);
    checkOutput("reset hcount", 64'(vout.hcount), 64'd0);
    checkOutput("reset is_scored", 64'(is_scored), 64'd0);
    checkOutput("reset round_done", 64'(round_done), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    passthrough("idle pass-through");

    // Reset in the middle of SHOT: outputs clear at once, then the pipeline refills from IDLE.
    game_state = SHOOTER;
    repeat (2) @(negedge clk);
    xpos = 12'd700;
    ypos = 12'd300;
    mouse_left = 1'b1;
    repeat (10) @(negedge clk);
    applyStimulus(100, 100, 12'hABC);
    repeat (2) @(negedge clk);
    checkOutput("pre-reset rgb", 64'(vout.rgb), 64'hABC);
    #2;
    rst = 1'b0;
    game_state = MENU;
    mouse_left = 1'b0;
    #1;
    checkOutput("mid-round reset rgb", 64'(vout.rgb), 64'd0);
    checkOutput("mid-round reset hsync", 64'(vout.hsync), 64'd0);
    checkOutput("mid-round reset is_scored", 64'(is_scored), 64'd0);
    checkOutput("mid-round reset round_done", 64'(round_done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(300, 300, 12'hABC);
    @(negedge clk);
    checkOutput("refill rgb", 64'(vout.rgb), 64'd0);
    @(negedge clk);
    checkOutput("post-reset idle rgb", 64'(vout.rgb), 64'hABC);

    run_round("goal",       0, 1'b0,   2,   6, 700, 300, 700, 300, 1'b1,   4, 1'b1,  -1, 100, 1);
    run_round("save",       1, 1'b0,   2,   6, 512, 400, 512, 400, 1'b1,   4, 1'b0,  -1,   0, 1);
    run_round("timeout",    1, 1'b0,  10,  20, 100, 100, 512, 400, 1'b0, 202, 1'b0,  -1,   0, 1);
    run_round("late click", 2, 1'b1, 200, 100, 700, 400, 700, 400, 1'b1, 202, 1'b0,  -1,   0, 1);
    run_round("abort",      0, 1'b0,   2,   6, 700, 300, 700, 300, 1'b1,   4, 1'b1, 150,  46, 0);
    passthrough("post-abort pass-through");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
